param_load_ctrl: RTL

PARAM_LOAD_CTRL -- requirements
Module: param_load_ctrl

---
 rtl/param_load_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/param_load_ctrl.sv
// Parameter-ROM fetch sequencer: walks NUM_FILTERS filter sets through FETCH/OFFER/RUN per pass.
// Optional feature: define PARAM_LOAD_CTRL_STALL_CNT_EN to add the 16-bit stall_cnt output.

module param_load_ctrl #(
  parameter int unsigned NUM_FILTERS = 6,
  // Must satisfy 2**ADDR_WIDTH >= NUM_FILTERS.
  parameter int unsigned ADDR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  rom_read,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  w_valid,
  input  logic                  w_ready,
  input  logic                  conv_done,
  output logic [ADDR_WIDTH-1:0] filter_idx,
  output logic                  busy,
  output logic                  done
`ifdef PARAM_LOAD_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StOffer,
    StRun,
    StFinish
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NUM_FILTERS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          idx_d   = '0;
        end
      end
      StFetch: begin
        state_d = abort ? StIdle : StOffer;
      end
      StOffer: begin
        if (abort) begin
          state_d = StIdle;
        end else if (w_ready) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // abort wins over conv_done, so the index is never advanced on an aborted edge
        if (abort) begin
          state_d = StIdle;
        end else if (conv_done) begin
          if (idx_q == LastIdx) begin
            state_d = StFinish;
          end else begin
            state_d = StFetch;
            idx_d   = idx_q + ADDR_WIDTH'(1);
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    rom_read   = (state_q == StFetch);
    w_valid    = (state_q == StOffer);
    done       = (state_q == StFinish);
    busy       = (state_q != StIdle);
    filter_idx = idx_q;
    rom_addr   = idx_q;
  end

`ifdef PARAM_LOAD_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      stall_cnt_q <= '0;
    end else if (w_valid && !w_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
